// File: rtl/step_pulse_generator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : step_pulse_generator                                       |
// | Brief   : Phase-accumulator step pulse source with fixed and hybrid  |
// |           per-second rate schedules, window and pulse counters.      |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module step_pulse_generator #(
    parameter int CLK_HZ = 100000000
) (
    input  logic        clk100MHz,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [1:0]  mode,
    output logic        X,
    output logic        running,
    output logic [7:0]  sec_count,
    output logic [19:0] pulse_total
);

    // Accumulator holds < CLK_HZ; adding a rate (< 256 <= CLK_HZ) stays below 2*CLK_HZ.
    localparam int                 c_ACC_W    = $clog2(CLK_HZ) + 1;
    localparam logic [c_ACC_W-1:0] c_CLK_HZ   = c_ACC_W'(CLK_HZ);
    localparam logic [c_ACC_W-1:0] c_WIN_LAST = c_ACC_W'(CLK_HZ - 1);
    localparam logic [c_ACC_W-1:0] c_ONE      = c_ACC_W'(1);
    localparam logic [0:0]         c_ST_IDLE  = 1'b0;
    localparam logic [0:0]         c_ST_RUN   = 1'b1;

    logic [0:0]         r_state;
    logic [0:0]         w_state_next;
    logic [c_ACC_W-1:0] r_acc;
    logic [c_ACC_W-1:0] r_cyc;
    logic [3:0]         r_hidx;
    logic [1:0]         r_mode;
    logic               r_x;
    logic [7:0]         r_sec;
    logic [19:0]        r_pulses;

    logic [7:0]         w_hyb_rate;
    logic [7:0]         w_rate;
    logic [c_ACC_W-1:0] w_sum;
    logic               w_fire;
    logic               w_win_end;
    logic               w_enter;
    logic               w_active;

    always_comb begin
        w_hyb_rate = 8'd20;
        case (r_hidx)
            4'd0:    w_hyb_rate = 8'd20;
            4'd1:    w_hyb_rate = 8'd33;
            4'd2:    w_hyb_rate = 8'd66;
            4'd3:    w_hyb_rate = 8'd27;
            4'd4:    w_hyb_rate = 8'd70;
            4'd5:    w_hyb_rate = 8'd30;
            4'd6:    w_hyb_rate = 8'd19;
            4'd7:    w_hyb_rate = 8'd30;
            4'd8:    w_hyb_rate = 8'd33;
            default: w_hyb_rate = 8'd20;
        endcase
    end

    always_comb begin
        w_rate = 8'd32;
        case (r_mode)
            2'd0:    w_rate = 8'd32;
            2'd1:    w_rate = 8'd64;
            2'd2:    w_rate = 8'd128;
            default: w_rate = w_hyb_rate;
        endcase
    end

    assign w_sum     = r_acc + c_ACC_W'(w_rate);
    assign w_fire    = (w_sum >= c_CLK_HZ);
    assign w_win_end = (r_cyc == c_WIN_LAST);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: if (start && !stop) w_state_next = c_ST_RUN;
            c_ST_RUN:  if (stop)           w_state_next = c_ST_IDLE;
            default:                       w_state_next = c_ST_IDLE;
        endcase
    end

    assign w_enter  = (r_state == c_ST_IDLE) && (w_state_next == c_ST_RUN);
    assign w_active = (r_state == c_ST_RUN) && !stop;

    always_ff @(posedge clk100MHz or posedge reset) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // A stopping cycle neither accumulates nor fires, so a pending pulse is dropped.
    always_ff @(posedge clk100MHz or posedge reset) begin
        if (reset) begin
            r_acc    <= '0;
            r_cyc    <= '0;
            r_hidx   <= 4'd0;
            r_mode   <= 2'd0;
            r_x      <= 1'b0;
            r_sec    <= 8'd0;
            r_pulses <= 20'd0;
        end else begin
            r_x <= 1'b0;
            if (w_enter) begin
                r_acc    <= '0;
                r_cyc    <= '0;
                r_hidx   <= 4'd0;
                r_mode   <= mode;
                r_sec    <= 8'd0;
                r_pulses <= 20'd0;
            end else if (w_active) begin
                r_acc <= w_fire ? (w_sum - c_CLK_HZ) : w_sum;
                r_x   <= w_fire;
                if (w_fire && (r_pulses != 20'hFFFFF)) begin
                    r_pulses <= r_pulses + 20'd1;
                end
                if (w_win_end) begin
                    r_cyc  <= '0;
                    r_hidx <= (r_hidx == 4'd8) ? 4'd0 : (r_hidx + 4'd1);
                    r_mode <= mode;
                    if (r_sec != 8'hFF) begin
                        r_sec <= r_sec + 8'd1;
                    end
                end else begin
                    r_cyc <= r_cyc + c_ONE;
                end
            end
        end
    end

    assign X           = r_x;
    assign running     = (r_state == c_ST_RUN);
    assign sec_count   = r_sec;
    assign pulse_total = r_pulses;

endmodule
`default_nettype wire

// File: tb/tb_step_pulse_generator.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_step_pulse_generator                                    |
// | Brief   : Directed, table-driven self-checking bench (CLK_HZ=1000).  |
// | Revision: 1.0 - initial release                                      |
// +----------------------------------------------------------------------+
module tb_step_pulse_generator;

    localparam int c_CLK_HZ = 1000;

    logic        clk100MHz = 1'b0;
    logic        reset     = 1'b1;
    logic        start     = 1'b0;
    logic        stop      = 1'b0;
    logic [1:0]  mode      = 2'd0;
    logic        X;
    logic        running;
    logic [7:0]  sec_count;
    logic [19:0] pulse_total;

    step_pulse_generator #(.CLK_HZ(c_CLK_HZ)) dut (
        .clk100MHz  (clk100MHz),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .mode       (mode),
        .X          (X),
        .running    (running),
        .sec_count  (sec_count),
        .pulse_total(pulse_total)
    );

    always #5 clk100MHz = ~clk100MHz;

    typedef struct {
        logic [1:0] mode;
        int         cycles;
        int         exp_pulses;
        int         exp_secs;
        int         exp_first;
    } vec_t;

    int   errors = 0;
    int   checks = 0;
    int   xcnt   = 0;
    int   b2b    = 0;
    logic prev_x = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One clock: inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk100MHz);
        #1;
        if (X) begin
            xcnt++;
            if (prev_x) b2b++;
        end
        prev_x = X;
    endtask

    task automatic begin_run(input logic [1:0] m);
        mode  = m;
        start = 1'b1;
        step();
        start = 1'b0;
        xcnt  = 0;
    endtask

    task automatic end_run();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    vec_t vecs[7];

    initial begin
        int first;
        int w1;
        int snap;
        int exp_hyb[10];

        vecs[0] = '{2'd0, 1000, 32,  1, 32};
        vecs[1] = '{2'd1, 1000, 64,  1, 16};
        vecs[2] = '{2'd2, 3000, 384, 3, 8};
        vecs[3] = '{2'd3, 1000, 20,  1, 50};
        vecs[4] = '{2'd0, 500,  16,  0, 32};
        vecs[5] = '{2'd2, 999,  127, 0, 8};
        vecs[6] = '{2'd1, 2000, 128, 2, 16};
        exp_hyb = '{20, 33, 66, 27, 70, 30, 19, 30, 33, 20};

        // Reset state, asserted from time zero
        #2;
        check("reset_X", int'(X), 0);
        check("reset_running", int'(running), 0);
        check("reset_sec", int'(sec_count), 0);
        check("reset_pulses", int'(pulse_total), 0);
        step();
        step();
        reset = 1'b0;
        step();
        step();
        check("idle_after_reset", int'(running), 0);

        // Table-driven fixed/hybrid runs
        for (int i = 0; i < 7; i++) begin
            begin_run(vecs[i].mode);
            check($sformatf("v%0d_running", i), int'(running), 1);
            check($sformatf("v%0d_sec_clear", i), int'(sec_count), 0);
            check($sformatf("v%0d_pulse_clear", i), int'(pulse_total), 0);
            first = -1;
            for (int k = 1; k <= vecs[i].cycles; k++) begin
                step();
                if (X && first < 0) first = k;
            end
            check($sformatf("v%0d_pulse_total", i), int'(pulse_total), vecs[i].exp_pulses);
            check($sformatf("v%0d_x_count", i), xcnt, vecs[i].exp_pulses);
            check($sformatf("v%0d_sec_count", i), int'(sec_count), vecs[i].exp_secs);
            check($sformatf("v%0d_first_k", i), first, vecs[i].exp_first);
            end_run();
            check($sformatf("v%0d_stopped", i), int'(running), 0);
            check($sformatf("v%0d_hold_pulses", i), int'(pulse_total), vecs[i].exp_pulses);
        end

        // Hybrid schedule over ten windows, including the wrap to index 0
        begin_run(2'd3);
        for (int w = 0; w < 10; w++) begin
            xcnt = 0;
            for (int k = 1; k <= c_CLK_HZ; k++) step();
            check($sformatf("hyb_win%0d", w), xcnt, exp_hyb[w]);
        end
        check("hyb_total", int'(pulse_total), 348);
        check("hyb_secs", int'(sec_count), 10);
        end_run();

        // Mode change mid-window applies only from the next window
        begin_run(2'd0);
        w1 = 0;
        for (int k = 1; k <= 2 * c_CLK_HZ; k++) begin
            if (k == 500) mode = 2'd1;
            step();
            if (k == c_CLK_HZ) w1 = xcnt;
        end
        check("switch_win1", w1, 32);
        check("switch_win2", xcnt - w1, 64);
        end_run();

        // Stop at k=700 in mode 1
        begin_run(2'd1);
        for (int k = 1; k <= 699; k++) step();
        end_run();
        check("stop_running", int'(running), 0);
        check("stop_X", int'(X), 0);
        check("stop_pulses", int'(pulse_total), 44);
        check("stop_secs", int'(sec_count), 0);
        snap = xcnt;
        for (int k = 0; k < 50; k++) step();
        check("stop_no_x", xcnt - snap, 0);
        check("stop_hold", int'(pulse_total), 44);
        begin_run(2'd0);
        check("restart_pulses", int'(pulse_total), 0);
        check("restart_running", int'(running), 1);
        end_run();

        // Stop on the cycle whose accumulation would fire: pulse must be dropped
        begin_run(2'd0);
        for (int k = 1; k <= 31; k++) step();
        end_run();
        check("pending_X", int'(X), 0);
        check("pending_pulses", int'(pulse_total), 0);
        step();
        check("pending_X_later", int'(X), 0);

        // start while running is ignored
        begin_run(2'd0);
        for (int k = 1; k <= 600; k++) begin
            start = (k == 301);
            step();
        end
        start = 1'b0;
        check("ign_start_pulses", int'(pulse_total), 19);
        check("ign_start_running", int'(running), 1);
        end_run();

        // Asynchronous reset mid-run at k=250
        begin_run(2'd2);
        for (int k = 1; k <= 249; k++) step();
        check("prereset_pulses", int'(pulse_total), 31);
        #3;
        reset = 1'b1;
        #1;
        check("areset_running", int'(running), 0);
        check("areset_X", int'(X), 0);
        check("areset_pulses", int'(pulse_total), 0);
        check("areset_secs", int'(sec_count), 0);
        step();
        reset = 1'b0;
        start = 1'b1;
        stop  = 1'b1;
        for (int k = 0; k < 3; k++) step();
        check("startstop_idle", int'(running), 0);
        start = 1'b0;
        stop  = 1'b0;
        for (int k = 0; k < 3; k++) step();
        check("post_reset_idle", int'(running), 0);
        check("post_reset_X", int'(X), 0);

        check("no_back_to_back", b2b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/step_pulse_generator.md
STEP_PULSE_GENERATOR -- requirements
Module: step_pulse_generator

Interface
REQ-001 Parameter CLK_HZ, default 100000000: clock cycles per one-second window; legal range 256..2^27.
REQ-002 Port clk100MHz  input  1  system clock; all logic is on its rising edge.
REQ-003 Port reset  input  1  asynchronous, active-high reset.
REQ-004 Port start  input  1  level-sampled each cycle; high in IDLE begins a run.
REQ-005 Port stop  input  1  level-sampled each cycle; high in RUN ends the run.
REQ-006 Port mode  input  2  step rate select: 0=32/s, 1=64/s, 2=128/s, 3=hybrid schedule.
REQ-007 Port X  output  1  registered step pulse, one cycle high per step; drives the step input of the activity trackers.
REQ-008 Port running  output  1  high while in RUN.
REQ-009 Port sec_count  output  8  completed one-second windows since the last start; saturates at 255.
REQ-010 Port pulse_total  output  20  X pulses emitted since the last start; saturates at 1048575.

Function
REQ-011 The FSM SHALL have two states, IDLE and RUN; IDLE->RUN when start=1 and stop=0; RUN->IDLE when stop=1.
REQ-012 Entering RUN SHALL clear the accumulator, the cycle counter, sec_count, pulse_total and the hybrid index, and SHALL latch mode.
REQ-013 In RUN, each cycle SHALL add the active rate N to a phase accumulator; when the sum is >= CLK_HZ, the block SHALL subtract CLK_HZ and assert X on the next cycle. The accumulator SHALL be wide enough that no overflow occurs.
REQ-014 Exactly N pulses SHALL occur in every CLK_HZ-cycle window, and X SHALL never be high on two consecutive cycles.
REQ-015 Cycle k=1 is the first RUN cycle. The window ends at cycle k=CLK_HZ, where the cycle counter wraps to 0 and sec_count increments.
REQ-016 Hybrid rate table by window index: 20, 33, 66, 27, 70, 30, 19, 30, 33. After index 8 the index returns to 0.
REQ-017 A change on mode during RUN SHALL take effect only at the next window boundary. The new mode and rate apply from cycle 1 of the next window, and the accumulator is not cleared.
REQ-018 pulse_total SHALL increment on the same edge that sets X.
REQ-019 start while in RUN SHALL be ignored. start=1 and stop=1 in IDLE SHALL leave the block in IDLE.
REQ-020 On RUN->IDLE: X SHALL be 0 from the next cycle, and no pending pulse is emitted. sec_count and pulse_total SHALL hold their values until the next start.
REQ-021 Outputs SHALL be glitch-free registered outputs; no combinational path SHALL exist from input to output.

Reset
REQ-022 With reset=1, the block SHALL be forced into IDLE immediately and asynchronously, with X=0, running=0, sec_count=0, pulse_total=0, and the accumulator, cycle counter and hybrid index at 0.
REQ-023 When reset is asserted mid-run, the block SHALL abort without completing the current pulse. After release it SHALL stay in IDLE until start.

Verification (CLK_HZ=1000)
REQ-024 mode=0, start pulse, run 1000 cycles -> 32 X pulses, first at k=32 (X high on cycle 33), sec_count=1, pulse_total=32.
REQ-025 mode=2, run 3000 cycles -> pulse_total=384, sec_count=3, no back-to-back X highs.
REQ-026 mode=3, run 10 windows -> per-window counts 20,33,66,27,70,30,19,30,33,20, pulse_total=348.
REQ-027 mode=0, switch to mode=1 at k=500 -> window 1 has 32 pulses, window 2 has 64.
REQ-028 Stop at k=700 in mode=1 -> X stays 0, running=0, sec_count=0, pulse_total=44; a later start clears both counters.
REQ-029 Async reset at k=250 mid-run -> all outputs 0 without waiting for a clock edge; start=stop=1 after release -> block stays IDLE.
